// File: rtl/mac_merge_tx_scheduler_if.sv
// Byte-level handshake between the MAC merge scheduler, the eMAC/pMAC sources and the PHY byte strobe.
interface mac_merge_tx_scheduler_if;
    logic       txReady;
    logic       preemptEn;
    logic       eTxReq;
    logic       pTxReq;
    logic       eTxLast;
    logic       pTxLast;
    logic [1:0] txSel;
    logic [7:0] txCode;
    logic       eTxAck;
    logic       pTxAck;
    logic       txMcrc;
    logic [1:0] frameCnt;
    logic [1:0] fragCnt;

    modport master (
        output txReady, preemptEn, eTxReq, pTxReq, eTxLast, pTxLast,
        input  txSel, txCode, eTxAck, pTxAck, txMcrc, frameCnt, fragCnt
    );

    modport slave (
        input  txReady, preemptEn, eTxReq, pTxReq, eTxLast, pTxLast,
        output txSel, txCode, eTxAck, pTxAck, txMcrc, frameCnt, fragCnt
    );
endinterface

// File: rtl/mac_merge_tx_scheduler.sv
// Express/preemptable MAC merge transmit scheduler: picks the byte source per PHY byte cycle,
// fragments pMAC frames for pending express traffic and generates preamble/SMD/frag-count codes.
module mac_merge_tx_scheduler #(
    parameter int MIN_FRAG  = 60,
    parameter int IPG_BYTES = 12
) (
    input  logic clk,
    input  logic reset_n,
    mac_merge_tx_scheduler_if.slave tx
);
    typedef enum logic [3:0] {
        IDLE, E_PRE, E_SMD, E_DATA, P_PRE, P_SMD, P_FRAG, P_DATA, P_MCRC, IPG
    } state_e;

    localparam logic [7:0] MIN_FRAG_B = 8'(MIN_FRAG);
    localparam logic [7:0] IPG_LAST   = 8'(IPG_BYTES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] frag_byte_q, frag_byte_d, frag_byte_inc;
    logic       open_q, open_d;
    logic [1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] frag_cnt_q, frag_cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] code_q, code_d;
    logic       mcrc_q, mcrc_d;
    logic       eack_q, eack_d;
    logic       pack_q, pack_d;

    // SMD-S and frag-count codes share one table
    function automatic logic [7:0] smd_s(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'hE6;
            2'd1:    return 8'h4C;
            2'd2:    return 8'h7F;
            default: return 8'hB3;
        endcase
    endfunction

    function automatic logic [7:0] smd_c(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h61;
            2'd1:    return 8'h52;
            2'd2:    return 8'h9E;
            default: return 8'h2A;
        endcase
    endfunction

    assign frag_byte_inc = (frag_byte_q == 8'hFF) ? 8'hFF : frag_byte_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frag_byte_d = frag_byte_q;
        open_d      = open_q;
        frame_cnt_d = frame_cnt_q;
        frag_cnt_d  = frag_cnt_q;
        if (tx.txReady) begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = 8'd0;
                    if (tx.eTxReq)                state_d = E_PRE;
                    else if (tx.pTxReq || open_q) state_d = P_PRE;
                end
                E_PRE: begin
                    if (cnt_q == 8'd6) state_d = E_SMD;
                    else               cnt_d   = cnt_q + 8'd1;
                end
                E_SMD:  state_d = E_DATA;
                E_DATA: begin
                    if (tx.eTxLast) begin
                        state_d = IPG;
                        cnt_d   = 8'd0;
                    end
                end
                // a continuation fragment carries one preamble byte fewer
                P_PRE: begin
                    if (cnt_q == (open_q ? 8'd5 : 8'd6)) state_d = P_SMD;
                    else                                 cnt_d   = cnt_q + 8'd1;
                end
                P_SMD: begin
                    frag_byte_d = 8'd0;
                    if (open_q) begin
                        state_d = P_FRAG;
                    end else begin
                        state_d = P_DATA;
                        open_d  = 1'b1;
                    end
                end
                P_FRAG: begin
                    state_d     = P_DATA;
                    frag_byte_d = 8'd0;
                end
                P_DATA: begin
                    frag_byte_d = frag_byte_inc;
                    if (tx.pTxLast) begin
                        state_d     = IPG;
                        cnt_d       = 8'd0;
                        open_d      = 1'b0;
                        frame_cnt_d = frame_cnt_q + 2'd1;
                        frag_cnt_d  = 2'd0;
                    end else if (tx.eTxReq && tx.preemptEn && frag_byte_inc >= MIN_FRAG_B) begin
                        state_d = P_MCRC;
                        cnt_d   = 8'd0;
                    end
                end
                P_MCRC: begin
                    if (cnt_q == 8'd3) begin
                        state_d    = IPG;
                        cnt_d      = 8'd0;
                        frag_cnt_d = frag_cnt_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                IPG: begin
                    if (cnt_q == IPG_LAST) state_d = IDLE;
                    else                   cnt_d   = cnt_q + 8'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registers line up with state_q
    always_comb begin
        sel_d  = 2'b00;
        code_d = 8'h00;
        mcrc_d = 1'b0;
        eack_d = 1'b0;
        pack_d = 1'b0;
        case (state_d)
            E_PRE, P_PRE: begin
                sel_d  = 2'b01;
                code_d = 8'h55;
            end
            E_SMD: begin
                sel_d  = 2'b01;
                code_d = 8'hD5;
            end
            P_SMD: begin
                sel_d  = 2'b01;
                code_d = open_d ? smd_c(frame_cnt_d) : smd_s(frame_cnt_d);
            end
            P_FRAG: begin
                sel_d  = 2'b01;
                code_d = smd_s(frag_cnt_d);
            end
            E_DATA: begin
                sel_d  = 2'b10;
                eack_d = 1'b1;
            end
            P_DATA: begin
                sel_d  = 2'b11;
                pack_d = 1'b1;
            end
            P_MCRC: begin
                sel_d  = 2'b11;
                mcrc_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            frag_byte_q <= 8'd0;
            open_q      <= 1'b0;
            frame_cnt_q <= 2'd0;
            frag_cnt_q  <= 2'd0;
            sel_q       <= 2'b00;
            code_q      <= 8'h00;
            mcrc_q      <= 1'b0;
            eack_q      <= 1'b0;
            pack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frag_byte_q <= frag_byte_d;
            open_q      <= open_d;
            frame_cnt_q <= frame_cnt_d;
            frag_cnt_q  <= frag_cnt_d;
            sel_q       <= sel_d;
            code_q      <= code_d;
            mcrc_q      <= mcrc_d;
            eack_q      <= eack_d;
            pack_q      <= pack_d;
        end
    end

    // Acks only count on a real byte cycle, so they are qualified by the strobe
    assign tx.txSel    = sel_q;
    assign tx.txCode   = code_q;
    assign tx.txMcrc   = mcrc_q;
    assign tx.eTxAck   = eack_q & tx.txReady;
    assign tx.pTxAck   = pack_q & tx.txReady;
    assign tx.frameCnt = frame_cnt_q;
    assign tx.fragCnt  = frag_cnt_q;
endmodule
